// File: rtl/c_wb_commit_unit.sv
// ============================================================================
// c_wb_commit_unit
// ----------------------------------------------------------------------------
// Writeback-stage commit unit. It takes the control bundle from the EX/WB
// pipeline register and commits it to architectural state:
//   * drives the register-file write port, with optional binary thresholding
//     of the result against a programmable signed threshold
//   * runs the data-memory store handshake (IDLE -> REQ -> WAIT -> IDLE)
//   * raises StallW to hold a store in WB until memory acknowledges it
//
// Optional feature (compile-time macro WB_STORE_TIMEOUT_EN):
//   When defined, a store that waits TIMEOUT_CYCLES cycles in WAIT without
//   mem_ack is abandoned and store_err pulses for one cycle. When undefined,
//   WAIT waits for mem_ack indefinitely and store_err is tied low.
//
// Parameters:
//   DATA_W         result/store data width
//   ADDR_W         store address width
//   TIMEOUT_CYCLES ack timeout (only with WB_STORE_TIMEOUT_EN), must be >= 2
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   RegWE_W_W, MemWriteW             WB instruction writes RF / is a store
//   en_threshold_W                   binarise result before the RF write
//   ResultW, RdW                     WB result and destination register
//   AddrW, WriteDataW                store address and data
//   thr_we, thr_wdata                threshold register load
//   StallW                           hold the EX/WB register
//   rf_we, rf_waddr, rf_wdata        register-file write port
//   mem_req_valid/ready/addr/wdata   store request channel (registered)
//   mem_ack                          store completion pulse
//   store_err                        one-cycle timeout pulse
// ============================================================================
module c_wb_commit_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWE_W_W,
    input  logic              MemWriteW,
    input  logic              en_threshold_W,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [4:0]        RdW,
    input  logic [ADDR_W-1:0] AddrW,
    input  logic [DATA_W-1:0] WriteDataW,
    input  logic              thr_we,
    input  logic [DATA_W-1:0] thr_wdata,
    output logic              StallW,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_ack,
    output logic              store_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] thr;
    logic              expire;   // timeout reached in WAIT without an ack
    logic              thr_hit;

    // ------------------------------------------------------------------
    // Optional ack timeout
    // ------------------------------------------------------------------
`ifdef WB_STORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    // The counter reads 0 in the first WAIT cycle, so TIMEOUT_CYCLES-1 marks
    // the last permitted cycle. A simultaneous ack wins over expiry.
    assign expire    = (state == WAIT) && !mem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign store_err = expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == REQ && mem_req_ready) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign store_err          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------
    // Store FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next; otherwise a
        // latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (MemWriteW)              state_next = REQ;
            REQ:     if (mem_req_ready)          state_next = WAIT;
            WAIT:    if (mem_ack || expire)      state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Once issued, the store is driven from latched data; a flush of the WB
    // controls does not cancel it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // register samples pre-edge values regardless of statement order.
            state         <= state_next;
            mem_req_valid <= (state_next == REQ);
            if (state == IDLE && MemWriteW) begin
                mem_req_addr  <= AddrW;
                mem_req_wdata <= WriteDataW;
            end
        end
    end

    // Stall drops in the ack (or expiry) cycle so the store leaves WB on
    // that edge and is never reissued.
    assign StallW = (state == IDLE && MemWriteW) ||
                    (state == REQ) ||
                    (state == WAIT && !mem_ack && !expire);

    // ------------------------------------------------------------------
    // Threshold register and register-file write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr <= '0;
        end else if (thr_we) begin
            thr <= thr_wdata;
        end
    end

    // A same-cycle thr_we only takes effect on the edge, so the compare
    // naturally sees the old threshold.
    assign thr_hit  = ($signed(ResultW) >= $signed(thr));
    assign rf_we    = RegWE_W_W && !StallW;
    assign rf_waddr = RdW;
    assign rf_wdata = en_threshold_W ? {{(DATA_W-1){1'b0}}, thr_hit} : ResultW;

endmodule
